id_exe_skid_reg: RTL
====================

ID_EXE_SKID_REG -- requirements
Module: id_exe_skid_reg

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, data/PC width; REG_W, default 4, register-address width; CMD_W, default 4, execute-command width; SHIFT_W, default 12, shift-operand width; IMM_W, default 24, branch-immediate width.
REQ-002 clk  in  1  clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 flush  in  1  synchronous kill of all held and incoming instructions.
REQ-005 up_valid  in  1  ID stage presents an instruction.
REQ-006 up_ready  out  1  block accepts an instruction this cycle.
REQ-007 ctrl_in  in  7  {wb_en, mem_r_en, mem_w_en, b, s, imm, c}.
REQ-008 pc_in, val_rn_in, val_rm_in  in  XLEN each  PC and operand values.
REQ-009 dest_in  in  REG_W; exe_cmd_in  in  CMD_W; shift_operand_in  in  SHIFT_W; signed_imm_in  in  IMM_W.
REQ-010 dn_valid  out  1  EXE stage has a valid instruction.
REQ-011 dn_ready  in  1  EXE stage consumes the instruction this cycle.
REQ-012 ctrl_out, pc_out, val_rn_out, val_rm_out, dest_out, exe_cmd_out, shift_operand_out, signed_imm_out  out  same widths as inputs.
REQ-013 stall_cnt, bubble_cnt  out  32 each  performance counters.

Function
REQ-014 Storage SHALL be two entries: main (drives outputs) and skid; each has a valid bit.
REQ-015 up_ready SHALL equal !skid_valid, registered, with no combinational path from dn_ready.
REQ-016 Accept occurs when up_valid && up_ready; consume occurs when dn_valid && dn_ready; dn_valid SHALL equal main_valid.
REQ-017 On accept, if main is empty or consumed in the same cycle, the beat SHALL load main; otherwise it SHALL load skid.
REQ-018 On consume with skid valid, skid SHALL move to main and skid_valid SHALL clear in the same edge.
REQ-019 Latency SHALL be one cycle from accept into an empty block to dn_valid.
REQ-020 Throughput SHALL be one instruction per cycle while dn_ready is held high.
REQ-021 Order SHALL be preserved; no beat is duplicated or dropped except by flush.
REQ-022 flush SHALL clear main_valid and skid_valid at the next edge, discard any beat accepted that cycle, and take priority over accept and consume.
REQ-023 ctrl_out SHALL be forced to all zeros whenever dn_valid is low, so bubbles never write a register or memory, or branch.
REQ-024 Data fields SHALL hold their last value while dn_valid is low.
REQ-025 When the block is full, accept is impossible; a simultaneous consume SHALL shift skid to main and raise up_ready on the following cycle.

Reset
REQ-026 While rst is low, main_valid, skid_valid, all output fields, and both counters SHALL be zero and up_ready SHALL be 1; this takes effect immediately, mid-transfer included.
REQ-027 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-028 With ID_EXE_PERF_CNT_EN defined:
- stall_cnt SHALL increment on each cycle with dn_valid && !dn_ready.
- bubble_cnt SHALL increment on each cycle with !dn_valid.
- Both counters SHALL saturate at 32'hFFFF_FFFF and be cleared only by reset.
REQ-029 Without ID_EXE_PERF_CNT_EN, both counters SHALL be tied to zero and no counter flops SHALL exist; the port list is unchanged.

Structure
REQ-030 Package id_exe_pkg SHALL hold default widths, ctrl bit-index constants (CTRL_WB..CTRL_C, CTRL_W=7), and a packed payload struct typedef.
REQ-031 One sub-module, id_exe_slot, SHALL implement a single payload-plus-valid entry, instantiated twice.

Verification
REQ-032 Bench SHALL cover streaming: dn_ready=1, ten beats with pc 0,4,..,36 -> outputs appear one cycle later in order, stall_cnt=0.
REQ-033 Bench SHALL cover skid fill: dn_ready=0, beats pc 0x10,0x14,0x18 -> first two held, up_ready=0 after second, third held off; dn_ready=1 -> 0x10 then 0x14 out, then 0x18 accepted.
REQ-034 Bench SHALL cover flush when full: flush=1 with up_valid=1 -> next cycle dn_valid=0, ctrl_out=0, up_ready=1, flushed beat never appears.
REQ-035 Bench SHALL cover async reset: rst low mid-stall between edges -> outputs zero immediately, counters zero.
REQ-036 Bench SHALL cover counter saturation (ID_EXE_PERF_CNT_EN): force stall_cnt to 32'hFFFF_FFFE, stall 3 cycles -> stall_cnt reads 32'hFFFF_FFFF.
REQ-037 Bench SHALL cover ctrl gating: wb_en_in=1 beat consumed, then idle -> ctrl_out=0 while pc_out holds its last value.

Source files
------------

// File: rtl/id_exe_pkg.sv
// Shared widths, control-bit positions and payload layout for the ID/EXE skid register.
package id_exe_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int REG_W_DEF   = 4;
  localparam int CMD_W_DEF   = 4;
  localparam int SHIFT_W_DEF = 12;
  localparam int IMM_W_DEF   = 24;

  localparam int CTRL_W   = 7;
  localparam int CTRL_WB  = 6;
  localparam int CTRL_MR  = 5;
  localparam int CTRL_MW  = 4;
  localparam int CTRL_B   = 3;
  localparam int CTRL_S   = 2;
  localparam int CTRL_IMM = 1;
  localparam int CTRL_C   = 0;

  typedef struct packed {
    logic [CTRL_W-1:0]      ctrl;
    logic [XLEN_DEF-1:0]    pc;
    logic [XLEN_DEF-1:0]    rn;
    logic [XLEN_DEF-1:0]    rm;
    logic [REG_W_DEF-1:0]   dest;
    logic [CMD_W_DEF-1:0]   cmd;
    logic [SHIFT_W_DEF-1:0] shift;
    logic [IMM_W_DEF-1:0]   imm;
  } payload_t;

  function automatic int payload_w(input int xlen, input int reg_w, input int cmd_w,
                                   input int shift_w, input int imm_w);
    return CTRL_W + 3 * xlen + reg_w + cmd_w + shift_w + imm_w;
  endfunction

endpackage

// File: rtl/id_exe_slot.sv
// One pipeline entry: a payload vector plus its valid bit.
module id_exe_slot
  import id_exe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Clearing only drops the valid bit so the payload keeps its last value.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/id_exe_skid_reg.sv
// ID->EXE pipeline register with a skid entry so up_ready is a pure flop output.
// Define ID_EXE_PERF_CNT_EN to build the saturating stall/bubble counters.
module id_exe_skid_reg
  import id_exe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int CMD_W   = CMD_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int IMM_W   = IMM_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic [XLEN-1:0]    pc_in,
  input  logic [XLEN-1:0]    val_rn_in,
  input  logic [XLEN-1:0]    val_rm_in,
  input  logic [REG_W-1:0]   dest_in,
  input  logic [CMD_W-1:0]   exe_cmd_in,
  input  logic [SHIFT_W-1:0] shift_operand_in,
  input  logic [IMM_W-1:0]   signed_imm_in,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic [XLEN-1:0]    pc_out,
  output logic [XLEN-1:0]    val_rn_out,
  output logic [XLEN-1:0]    val_rm_out,
  output logic [REG_W-1:0]   dest_out,
  output logic [CMD_W-1:0]   exe_cmd_out,
  output logic [SHIFT_W-1:0] shift_operand_out,
  output logic [IMM_W-1:0]   signed_imm_out,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bubble_cnt
);

  localparam int PW = payload_w(XLEN, REG_W, CMD_W, SHIFT_W, IMM_W);

  logic [PW-1:0]     in_pay, main_pay, skid_pay, main_load_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_valid, skid_valid;
  logic              accept, consume;
  logic              main_load, main_clear, main_src_skid;
  logic              skid_load, skid_clear;

  assign in_pay = {ctrl_in, pc_in, val_rn_in, val_rm_in, dest_in,
                   exe_cmd_in, shift_operand_in, signed_imm_in};

  assign up_ready = !skid_valid;
  assign dn_valid = main_valid;
  assign accept   = up_valid && up_ready;
  assign consume  = main_valid && dn_ready;

  // Flush wins; otherwise skid refills main first, then the incoming beat goes wherever there is room.
  always_comb begin
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_src_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      if (consume && skid_valid) begin
        main_load     = 1'b1;
        main_src_skid = 1'b1;
        skid_clear    = 1'b1;
      end else if (accept && (!main_valid || consume)) begin
        main_load = 1'b1;
      end else if (consume) begin
        main_clear = 1'b1;
      end
      if (accept && main_valid && !consume) begin
        skid_load = 1'b1;
      end
    end
  end

  assign main_load_data = main_src_skid ? skid_pay : in_pay;

  id_exe_slot #(.W(PW)) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .clear     (main_clear),
    .load_data (main_load_data),
    .valid     (main_valid),
    .data      (main_pay)
  );

  id_exe_slot #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (in_pay),
    .valid     (skid_valid),
    .data      (skid_pay)
  );

  assign {main_ctrl, pc_out, val_rn_out, val_rm_out, dest_out,
          exe_cmd_out, shift_operand_out, signed_imm_out} = main_pay;

  // Bubbles must never write, store or branch, so control is gated by valid.
  assign ctrl_out = main_valid ? main_ctrl : '0;

`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid && !dn_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!main_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
